// File: rtl/sonic_dec_iter_128x256.sv
// Iterative Sonic-128 decryption core: one inverse round per clock, round keys
// applied in reverse order from an internal resettable key file.
module sonic_dec_iter_128x256 #(
  parameter int NR = 12,
  parameter int AW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rk_wr_en,
  input  logic [AW-1:0]   rk_wr_addr,
  input  logic [63:0]     rk_wr_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [63:0]    key_q [NR];

  logic           key_we;
  logic [63:0]    x_w, y_w, t_w, r_w, l_w, rk_w;

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // M = z*(1+a) with a = z^7+z^9 in GF(2)[z]/(z^64+1); a^64 = 0, so
  // (1+a)^-1 = prod_k (1 + a^(2^k)). The k=5 factor is 1 (z^32 cancels).
  function automatic logic [63:0] minv(input logic [63:0] v);
    logic [63:0] w;
    w = v;
    w = w ^ rotl64(w, 7)  ^ rotl64(w, 9);
    w = w ^ rotl64(w, 14) ^ rotl64(w, 18);
    w = w ^ rotl64(w, 28) ^ rotl64(w, 36);
    w = w ^ rotl64(w, 56) ^ rotl64(w, 8);
    w = w ^ rotl64(w, 48) ^ rotl64(w, 16);
    return rotl64(w, 63);
  endfunction

  assign key_we = rk_wr_en && (state_q == S_IDLE);

  // Addresses >= NR match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) key_q[i] <= '0;
    end else if (key_we) begin
      for (int i = 0; i < NR; i++) begin
        if (rk_wr_addr == AW'(i)) key_q[i] <= rk_wr_data;
      end
    end
  end

  assign y_w  = st_q[127:64];
  assign x_w  = st_q[63:0];
  assign rk_w = key_q[cnt_q];

  // Undo the bit spread: 47 is the inverse of 15 mod 64.
  for (genvar gi = 0; gi < 64; gi++) begin : g_unperm
    assign t_w[gi] = x_w[(47 * gi) % 64];
  end

  assign r_w = minv(y_w ^ rk_w);
  assign l_w = t_w ^ (rotl64(r_w, 12) & r_w) ^ rotl64(r_w, 1);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          cnt_d   = AW'(NR - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d = {l_w, r_w};
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = !rst && (state_q == S_IDLE);
  assign out_valid = !rst && (state_q == S_DONE);
  assign busy      = !rst && ((state_q == S_RUN) || (state_q == S_DONE));
  assign out_data  = st_q;

endmodule

// File: tb/tb_sonic_dec_iter_128x256.sv
// Scoreboard bench: blocks encrypted by a forward-round model, decrypted by the
// core, checked against the original plaintext by an independent monitor.
module tb_sonic_dec_iter_128x256;
  localparam int NR = 12;
  localparam int AW = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rk_wr_en;
  logic [AW-1:0] rk_wr_addr;
  logic [63:0]   rk_wr_data;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0]  in_data, out_data;

  logic          rk1_wr_en;
  logic [0:0]    rk1_wr_addr;
  logic [63:0]   rk1_wr_data;
  logic          in1_valid, in1_ready, out1_valid, out1_ready, busy1;
  logic [127:0]  in1_data, out1_data;

  sonic_dec_iter_128x256 #(.NR(NR)) u_dut (
    .clk(clk), .rst(rst),
    .rk_wr_en(rk_wr_en), .rk_wr_addr(rk_wr_addr), .rk_wr_data(rk_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  sonic_dec_iter_128x256 #(.NR(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .rk_wr_en(rk1_wr_en), .rk_wr_addr(rk1_wr_addr), .rk_wr_data(rk1_wr_data),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .busy(busy1)
  );

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t         q[$];
  exp_t         q1[$];
  logic [63:0]  kmod [NR];
  int           cyc = 0;
  int           tmo_errs = 0;
  bit           done = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] s, input logic [63:0] k);
    logic [63:0] l, r, y, t, x;
    l = s[127:64];
    r = s[63:0];
    y = rl(r, 1) ^ rl(r, 8) ^ rl(r, 10) ^ k;
    t = l ^ (rl(r, 12) & r) ^ rl(r, 1);
    for (int i = 0; i < 64; i++) x[i] = t[(15 * i) % 64];
    return {y, x};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p;
    for (int r = 0; r < NR; r++) s = fwd(s, kmod[r]);
    return s;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !busy && !out_valid) ok = 1'b1;
    end
    if (!ok) begin
      tmo_errs++;
      $display("FAIL wait_idle timeout: got busy=%0b required idle", busy);
    end
    tick();
  endtask

  task automatic wr_key(input logic [AW-1:0] a, input logic [63:0] d);
    wait_idle();
    rk_wr_en = 1'b1; rk_wr_addr = a; rk_wr_data = d;
    tick();
    rk_wr_en = 1'b0;
    if (a < NR) kmod[a] = d;
  endtask

  task automatic send12(input logic [127:0] p, input bit wr,
                        input logic [AW-1:0] wa, input logic [63:0] wd);
    bit ok;
    if (wr && wa < NR) kmod[wa] = wd;
    in_data  = encrypt(p);
    in_valid = 1'b1;
    if (wr) begin
      rk_wr_en = 1'b1; rk_wr_addr = wa; rk_wr_data = wd;
    end
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      tmo_errs++;
      $display("FAIL accept timeout: got in_ready=%0b required 1", in_ready);
      in_valid = 1'b0; rk_wr_en = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    rk_wr_en = 1'b0;
    q.push_back('{p, cyc});
  endtask

  task automatic wr1(input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in1_ready && !busy1) ok = 1'b1;
    end
    if (!ok) begin
      tmo_errs++;
      $display("FAIL wr1 idle timeout: got busy1=%0b required 0", busy1);
    end
    tick();
    rk1_wr_en = 1'b1; rk1_wr_addr = 1'b0; rk1_wr_data = d;
    tick();
    rk1_wr_en = 1'b0;
  endtask

  task automatic send1(input logic [127:0] c, input logic [127:0] e);
    bit ok;
    in1_data  = c;
    in1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in1_ready) ok = 1'b1;
    end
    if (!ok) begin
      tmo_errs++;
      $display("FAIL accept1 timeout: got in1_ready=%0b required 1", in1_ready);
      in1_valid = 1'b0;
      return;
    end
    tick();
    in1_valid = 1'b0;
    q1.push_back('{e, cyc});
  endtask

  initial begin
    logic [127:0] p;
    logic [63:0]  k;
    bit ok;
    rst = 1'b1;
    rk_wr_en = 1'b0; rk_wr_addr = '0; rk_wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rk1_wr_en = 1'b0; rk1_wr_addr = '0; rk1_wr_data = '0;
    in1_valid = 1'b0; in1_data = '0; out1_ready = 1'b1;
    for (int i = 0; i < NR; i++) kmod[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    // NR=1 directed vectors, then random single rounds
    wr1(64'h1);
    send1(128'h0000000000000001_0000000000000000, 128'h0);
    wr1(64'h0);
    send1(128'h1, 128'h0000000000000001_0000000000000000);
    send1(128'h0000000000000000_0000800000000000, 128'h0000000000000002_0000000000000000);
    for (int n = 0; n < 20; n++) begin
      k = rand64();
      p = rand128();
      wr1(k);
      send1(fwd(p, k), p);
    end

    // NR=12 random keys and plaintexts
    for (int i = 0; i < NR; i++) wr_key(AW'(i), rand64());
    for (int n = 0; n < 1000; n++) begin
      send12(rand128(), 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // backpressure in DONE with ignored in_valid
    wait_idle();
    out_ready = 1'b0;
    send12(rand128(), 1'b0, '0, '0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) begin
      tmo_errs++;
      $display("FAIL out_valid timeout: got 0 required 1");
    end
    tick();
    in_valid = 1'b1;
    in_data  = rand128();
    repeat (5) tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // dropped key writes: during RUN and out of range
    wait_idle();
    send12(rand128(), 1'b0, '0, '0);
    tick(); tick();
    rk_wr_en = 1'b1; rk_wr_addr = AW'(3); rk_wr_data = rand64();
    tick();
    rk_wr_en = 1'b0;
    wr_key(AW'(NR), rand64());
    for (int n = 0; n < 4; n++) send12(rand128(), 1'b0, '0, '0);
    // write in the same cycle as accept takes effect
    wait_idle();
    send12(rand128(), 1'b1, AW'(NR - 1), rand64());
    wait_idle();
    send12(rand128(), 1'b1, AW'(0), rand64());
    for (int n = 0; n < 3; n++) send12(rand128(), 1'b0, '0, '0);

    // reset in the 4th round cycle
    wait_idle();
    send12(rand128(), 1'b0, '0, '0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < NR; i++) kmod[i] = '0;
    send12(rand128(), 1'b0, '0, '0);
    for (int i = 0; i < NR; i++) wr_key(AW'(i), rand64());
    for (int n = 0; n < 10; n++) send12(rand128(), 1'b0, '0, '0);

    wait_idle();
    repeat (3) tick();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    logic vld_prev, hs_prev, rst_prev;
    logic [127:0] data_prev;
    int nblk;
    vld_prev = 1'b0; hs_prev = 1'b0; rst_prev = 1'b0; data_prev = '0; nblk = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("timeouts", tmo_errs, 0);
        chk("queue_drained", q.size() + q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (cyc > 90000) begin
        $display("FAIL watchdog: got cycle %0d required < 90000", cyc);
        $fatal(1);
      end
      if (rst) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        if (rst_prev) chk("rst_out_data", out_data, 0);
      end else begin
        if (rst_prev) begin
          chk("post_rst_in_ready", in_ready, 1);
          chk("post_rst_out_valid", out_valid, 0);
          chk("post_rst_busy", busy, 0);
          chk("post_rst_out_data", out_data, 0);
        end
        if (busy) chk("busy_in_ready", in_ready, 0);
        if (hs_prev) begin
          chk("done_to_idle", {out_valid, busy, in_ready}, 3'b001);
        end else if (vld_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, data_prev);
        end
        if (out_valid && !vld_prev) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out: got out_valid=1 required 0 (cycle %0d)", cyc);
          end else begin
            chk("latency", cyc, q[0].acc + NR);
          end
        end
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("data", out_data, e.data);
          nblk++;
          $display("blk %0d: out=%h exp=%h", nblk, out_data, e.data);
        end
        if (out1_valid) begin
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out1: got out1_valid=1 required 0 (cycle %0d)", cyc);
          end else begin
            e = q1.pop_front();
            chk("latency1", cyc, e.acc + 1);
            chk("data1", out1_data, e.data);
            $display("blk1: out=%h exp=%h", out1_data, e.data);
          end
        end
      end
      rst_prev  = rst;
      vld_prev  = out_valid;
      hs_prev   = out_valid && out_ready;
      data_prev = out_data;
    end
  end

endmodule
